// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART control blocks: arbiter state encoding,
// bit timing and derived frame-gap / watchdog defaults.
package uart_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } arb_state_t;

    localparam int CLKS_PER_BIT           = 434;
    localparam int DEFAULT_GAP_CYCLES     = CLKS_PER_BIT;
    // A 10-bit frame plus generous slack: about 20 bit times.
    localparam int DEFAULT_TIMEOUT_CYCLES = 20 * CLKS_PER_BIT;

    // Width of a counter that must hold 0..max_val, never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin search: first set request at or above ptr,
// wrapping to the lowest set request when nothing above ptr is pending.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);

    logic          hi_found;
    logic          lo_found;
    logic [IW-1:0] hi_idx;
    logic [IW-1:0] lo_idx;

    // Descending scan so the lowest qualifying index is the one left standing.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_found = 1'b1;
                lo_idx   = IW'(i);
                if (IW'(i) >= ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = IW'(i);
                end
            end
        end
    end

    assign valid = lo_found;
    assign idx   = hi_found ? hi_idx : lo_idx;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte sources: round-robin grant,
// data-valid handshake, post-frame guard gap and a stall watchdog.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int GAP_CYCLES     = DEFAULT_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [8*NUM_REQ-1:0]       i_req_data,
    output logic [NUM_REQ-1:0]         o_ack,
    output logic [NUM_REQ-1:0]         o_done,
    output logic                       o_timeout,
    output logic                       o_busy,
    output logic [$clog2(NUM_REQ)-1:0] o_owner,
    output logic [7:0]                 o_tx_byte,
    output logic                       o_tx_dv,
    input  logic                       i_tx_dv_ack,
    input  logic                       i_tx_complete,
    output arb_state_t                 o_state
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int GW = cnt_width(GAP_CYCLES);
    localparam int WW = cnt_width(TIMEOUT_CYCLES);

    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [GW-1:0] GAP_MAX  = GW'(GAP_CYCLES);
    localparam logic [WW-1:0] WD_LAST  = WW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [WW-1:0] WD_MAX   = WW'(TIMEOUT_CYCLES);
    localparam arb_state_t AFTER_FRAME = (GAP_CYCLES > 0) ? GAP : IDLE;

    arb_state_t         state_q, state_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [7:0]         tx_byte_q, tx_byte_d;
    logic               tx_dv_q, tx_dv_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               timeout_q, timeout_d;
    logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
    logic [WW-1:0]      wdog_q, wdog_d;

    logic               pick_valid;
    logic [IW-1:0]      pick_idx;
    logic [7:0]         pick_byte;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req   (i_req),
        .ptr   (rr_ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        pick_byte = 8'h00;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick_idx == IW'(k)) pick_byte = i_req_data[8*k +: 8];
        end
    end

    // Handshake: o_tx_dv is a valid held from launch until the transmitter
    // returns i_tx_dv_ack (its ready); the byte is taken in the cycle both are
    // high, and o_tx_dv is low from the following edge.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        tx_byte_d = tx_byte_q;
        tx_dv_d   = tx_dv_q;
        ack_d     = '0;
        done_d    = '0;
        timeout_d = 1'b0;
        gap_cnt_d = gap_cnt_q;
        wdog_d    = wdog_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d   = LAUNCH;
                    owner_d   = pick_idx;
                    tx_byte_d = pick_byte;
                    tx_dv_d   = 1'b1;
                    ack_d     = NUM_REQ'(1) << pick_idx;
                    rr_ptr_d  = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + IW'(1);
                    wdog_d    = '0;
                end
            end
            LAUNCH, WAIT_DONE: begin
                wdog_d = (wdog_q == WD_MAX) ? wdog_q : wdog_q + WW'(1);
                // Completion is checked first so it beats a coincident watchdog expiry.
                if (i_tx_complete && (state_q == WAIT_DONE || i_tx_dv_ack)) begin
                    done_d    = NUM_REQ'(1) << owner_q;
                    tx_dv_d   = 1'b0;
                    state_d   = AFTER_FRAME;
                    gap_cnt_d = '0;
                end else if (wdog_q >= WD_LAST) begin
                    done_d    = NUM_REQ'(1) << owner_q;
                    timeout_d = 1'b1;
                    tx_dv_d   = 1'b0;
                    state_d   = AFTER_FRAME;
                    gap_cnt_d = '0;
                end else if (state_q == LAUNCH && i_tx_dv_ack) begin
                    tx_dv_d = 1'b0;
                    state_d = WAIT_DONE;
                end
            end
            GAP: begin
                gap_cnt_d = (gap_cnt_q == GAP_MAX) ? gap_cnt_q : gap_cnt_q + GW'(1);
                if (gap_cnt_q >= GAP_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            tx_byte_q <= 8'h00;
            tx_dv_q   <= 1'b0;
            ack_q     <= '0;
            done_q    <= '0;
            timeout_q <= 1'b0;
            gap_cnt_q <= '0;
            wdog_q    <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            tx_byte_q <= tx_byte_d;
            tx_dv_q   <= tx_dv_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            gap_cnt_q <= gap_cnt_d;
            wdog_q    <= wdog_d;
        end
    end

    assign o_ack     = ack_q;
    assign o_done    = done_q;
    assign o_timeout = timeout_q;
    assign o_busy    = (state_q != IDLE);
    assign o_owner   = owner_q;
    assign o_tx_byte = tx_byte_q;
    assign o_tx_dv   = tx_dv_q;
    assign o_state   = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: table of directed frames, hand-written reset and
// withdrawal sequences, then random frames predicted by a transaction-level model.
module tb_uart_tx_arbiter;
    import uart_ctrl_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int GAP     = 434;
    localparam int TMO     = 8680;

    logic                 i_clk;
    logic                 i_rst_n;
    logic [NUM_REQ-1:0]   i_req;
    logic [8*NUM_REQ-1:0] i_req_data;
    logic [NUM_REQ-1:0]   o_ack;
    logic [NUM_REQ-1:0]   o_done;
    logic                 o_timeout;
    logic                 o_busy;
    logic [0:0]           o_owner;
    logic [7:0]           o_tx_byte;
    logic                 o_tx_dv;
    logic                 i_tx_dv_ack;
    logic                 i_tx_complete;
    arb_state_t           o_state;

    uart_tx_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_req         (i_req),
        .i_req_data    (i_req_data),
        .o_ack         (o_ack),
        .o_done        (o_done),
        .o_timeout     (o_timeout),
        .o_busy        (o_busy),
        .o_owner       (o_owner),
        .o_tx_byte     (o_tx_byte),
        .o_tx_dv       (o_tx_dv),
        .i_tx_dv_ack   (i_tx_dv_ack),
        .i_tx_complete (i_tx_complete),
        .o_state       (o_state)
    );

    // Clock and run-time bound
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running at %0t, limit 2000000", $time);
        $fatal(1);
    end

    // Scoreboard state
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_q[$];
    int          model_ptr;

    typedef struct {
        logic [1:0] req;
        logic [7:0] d0;
        logic [7:0] d1;
        int         ack_dly;
        int         cmp_dly;
        bit         hold;
        logic [1:0] side;
        int         exp_owner;
        logic [7:0] exp_byte;
        bit         exp_tmo;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // At most one ack and one done bit in any cycle.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            checks++;
            if (!$onehot0(o_ack) || !$onehot0(o_done)) begin
                failures++;
                $display("FAIL onehot: ack=%b done=%b at t=%0t", o_ack, o_done, $time);
            end
        end
    end

    // Driver: apply one request pattern and play the transmitter side.
    // a = cycles o_tx_dv stays high before the ack edge, c = cycles from launch
    // to the edge that takes completion (0 = transmitter stalls forever).
    // Every cycle from launch until the arbiter is idle again is checked
    // against the timing predicted from those two numbers.
    task automatic run_frame(input logic [1:0] req, input logic [7:0] d0, input logic [7:0] d1,
                             input int a, input int c, input bit hold, input logic [1:0] side,
                             input int exp_owner, input logic [7:0] exp_byte, input bit exp_tmo);
        int         e;
        logic [1:0] onehot;
        logic [1:0] base;
        logic       exp_dv;
        logic       exp_busy;
        logic       exp_to;
        logic [1:0] exp_done;
        logic [1:0] exp_ack;
        e      = exp_tmo ? TMO : c;
        onehot = 2'(1 << exp_owner);
        base   = hold ? req : 2'b00;
        exp_q.push_back({8'(exp_owner), exp_byte});
        i_req         = req;
        i_req_data    = {d1, d0};
        i_tx_dv_ack   = 1'b0;
        i_tx_complete = 1'b0;
        for (int m = 0; m <= e + GAP; m++) begin
            @(negedge i_clk);
            if (m == 0) begin
                check("grant", {8'(o_owner), o_tx_byte}, 64'(exp_q.pop_front()));
            end
            exp_dv   = (m < a) && (m < e);
            exp_busy = (m < e + GAP);
            exp_to   = exp_tmo && (m == e);
            exp_done = (m == e) ? onehot : 2'b00;
            exp_ack  = (m == 0) ? onehot : 2'b00;
            check("status{dv,busy,tmo,done,ack}",
                  {o_tx_dv, o_busy, o_timeout, o_done, o_ack},
                  {exp_dv, exp_busy, exp_to, exp_done, exp_ack});
            if (m == e) check("owner_at_done", {8'(o_owner), o_tx_byte}, {8'(exp_owner), exp_byte});
            i_req         = base | (((m >= a) && (m < e + GAP - 1)) ? side : 2'b00);
            i_tx_dv_ack   = (m == a - 1);
            i_tx_complete = (c != 0) && (m == c - 1);
        end
        i_tx_dv_ack   = 1'b0;
        i_tx_complete = 1'b0;
    endtask

    task automatic check_reset_state(input string name);
        check(name, {o_tx_dv, o_busy, o_timeout, o_done, o_ack, o_owner, o_tx_byte, 2'(o_state)}, 64'h0);
    endtask

    initial begin
        logic [1:0] rq;
        logic [7:0] rd0;
        logic [7:0] rd1;
        int         ra;
        int         rc;
        bit         rh;
        int         own;
        logic [7:0] ob;

        vecs[0]  = '{2'b11, 8'h31, 8'h32, 1, 50,   1, 2'b00, 0, 8'h31, 0};
        vecs[1]  = '{2'b11, 8'h31, 8'h32, 1, 50,   1, 2'b00, 1, 8'h32, 0};
        vecs[2]  = '{2'b11, 8'h31, 8'h32, 1, 50,   1, 2'b00, 0, 8'h31, 0};
        vecs[3]  = '{2'b11, 8'h31, 8'h32, 1, 50,   0, 2'b00, 1, 8'h32, 0};
        vecs[4]  = '{2'b01, 8'h41, 8'h00, 2, 4340, 0, 2'b00, 0, 8'h41, 0};
        vecs[5]  = '{2'b01, 8'h5a, 8'h00, 1, 0,    0, 2'b00, 0, 8'h5a, 1};
        vecs[6]  = '{2'b10, 8'h00, 8'h77, 3, 100,  0, 2'b00, 1, 8'h77, 0};
        vecs[7]  = '{2'b10, 8'h00, 8'h88, 2, 2,    0, 2'b00, 1, 8'h88, 0};
        vecs[8]  = '{2'b01, 8'hc3, 8'h00, 1, TMO,  0, 2'b00, 0, 8'hc3, 0};
        vecs[9]  = '{2'b01, 8'he5, 8'h00, 1, 20,   0, 2'b00, 0, 8'he5, 0};
        vecs[10] = '{2'b01, 8'h10, 8'h20, 1, 30,   0, 2'b10, 0, 8'h10, 0};

        // Reset
        i_rst_n       = 1'b0;
        i_req         = '0;
        i_req_data    = '0;
        i_tx_dv_ack   = 1'b0;
        i_tx_complete = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check_reset_state("reset_values");
        i_rst_n = 1'b1;
        repeat (2) begin
            @(negedge i_clk);
            check("idle_no_req", {o_busy, o_ack, o_tx_dv}, 64'h0);
        end

        // Directed table
        for (int i = 0; i < 11; i++) begin
            run_frame(vecs[i].req, vecs[i].d0, vecs[i].d1, vecs[i].ack_dly, vecs[i].cmp_dly,
                      vecs[i].hold, vecs[i].side, vecs[i].exp_owner, vecs[i].exp_byte, vecs[i].exp_tmo);
        end
        // Requester 1 withdrew during the gap: it must never be granted.
        i_req = '0;
        repeat (5) begin
            @(negedge i_clk);
            check("withdrawn_idle", {o_busy, o_ack, o_tx_dv}, 64'h0);
        end

        // Reset in WAIT_DONE: frame dropped silently, pointer back to 0
        i_req      = 2'b01;
        i_req_data = {8'h99, 8'h5a};
        @(negedge i_clk);
        check("rst_seq_grant", {o_ack, o_tx_dv}, {2'b01, 1'b1});
        i_req       = 2'b00;
        i_tx_dv_ack = 1'b1;
        @(negedge i_clk);
        i_tx_dv_ack = 1'b0;
        check("rst_seq_wait_state", {o_tx_dv, 2'(o_state)}, {1'b0, 2'(WAIT_DONE)});
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        check_reset_state("reset_mid_frame");
        i_rst_n = 1'b1;
        repeat (4) begin
            @(negedge i_clk);
            check("no_done_after_reset", {o_done, o_busy, o_tx_dv, o_timeout}, 64'h0);
        end
        run_frame(2'b11, 8'h3c, 8'h3d, 1, 40, 0, 2'b00, 0, 8'h3c, 0);
        i_req = '0;

        // Random frames against the round-robin model
        model_ptr = 1;
        for (int n = 0; n < 25; n++) begin
            rq  = 2'($urandom_range(1, 3));
            rd0 = 8'($urandom_range(0, 255));
            rd1 = 8'($urandom_range(0, 255));
            ra  = $urandom_range(1, 4);
            rc  = $urandom_range(ra, ra + 40);
            rh  = 1'($urandom_range(0, 1));
            own = -1;
            for (int off = 0; off < NUM_REQ; off++) begin
                if (own < 0 && ((rq >> ((model_ptr + off) % NUM_REQ)) & 2'b01) != 2'b00)
                    own = (model_ptr + off) % NUM_REQ;
            end
            model_ptr = (own + 1) % NUM_REQ;
            ob = (own == 0) ? rd0 : rd1;
            run_frame(rq, rd0, rd1, ra, rc, rh, 2'b00, own, ob, 0);
            if (!rh) begin
                i_req = '0;
                repeat ($urandom_range(0, 3)) begin
                    @(negedge i_clk);
                    check("rand_idle", {o_busy, o_ack}, 64'h0);
                end
            end
        end
        i_req = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
